// File: rtl/control_sequencer_if.sv
// Control sequencer bundle: IR/handshake inputs and datapath strobes.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if;
  logic        start;
  logic        mem_ready;
  logic [31:0] IR;

  logic        PCout;
  logic        Zlowout;
  logic        Zhighout;
  logic        MDRout;
  logic        MARin;
  logic        Zin;
  logic        PCin;
  logic        MDRin;
  logic        IRin;
  logic        Yin;
  logic        IncPC;
  logic        Read;
  logic        HIin;
  logic        LOin;

  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;

  logic [4:0]  alu_op;
  logic        run;
  logic        illegal;

  modport master (
    input  start, mem_ready, IR,
    output PCout, Zlowout, Zhighout, MDRout,
    output MARin, Zin, PCin, MDRin, IRin, Yin,
    output IncPC, Read, HIin, LOin,
    output Gra, Grb, Grc, Rin, Rout,
    output alu_op, run, illegal
  );

  modport slave (
    output start, mem_ready, IR,
    input  PCout, Zlowout, Zhighout, MDRout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin,
    input  IncPC, Read, HIin, LOin,
    input  Gra, Grb, Grc, Rin, Rout,
    input  alu_op, run, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/execute control sequencer, Moore outputs from state and IR.
// Define MEM_WAIT_EN to stall T1 until mem_ready.
module control_sequencer (
  input logic                 clock,
  input logic                 reset,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_TWO,
    C_UNARY,
    C_MULDIV,
    C_NOP,
    C_HALT,
    C_ILL
  } class_e;

  state_e     state_q;
  state_e     state_d;
  class_e     cls;
  logic [4:0] opc;
  logic       unused_ir;

  assign opc = bus.IR[31:27];

  // Register fields only feed the external select encoder.
`ifdef MEM_WAIT_EN
  assign unused_ir = ^bus.IR[26:0];
`else
  assign unused_ir = ^{bus.IR[26:0], bus.mem_ready};
`endif

  always_comb begin
    cls = C_ILL;
    unique case (opc)
      5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000,
      5'b01001, 5'b01010, 5'b01011:
        cls = C_TWO;
      5'b10001, 5'b10010:
        cls = C_UNARY;
      5'b01111, 5'b10000:
        cls = C_MULDIV;
      5'b11010:
        cls = C_NOP;
      5'b11011:
        cls = C_HALT;
      default:
        cls = C_ILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_T0;
      end
      S_T0: state_d = S_T1;
      S_T1: begin
`ifdef MEM_WAIT_EN
        if (bus.mem_ready) state_d = S_T2;
`else
        state_d = S_T2;
`endif
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        unique case (cls)
          C_TWO:    state_d = S_T4;
          C_UNARY:  state_d = S_T4;
          C_MULDIV: state_d = S_T4;
          C_HALT:   state_d = S_HALT;
          default:  state_d = S_T0;
        endcase
      end
      S_T4: begin
        unique case (cls)
          C_TWO:    state_d = S_T5;
          C_MULDIV: state_d = S_T5;
          default:  state_d = S_T0;
        endcase
      end
      S_T5: begin
        if (cls == C_MULDIV) state_d = S_T6;
        else                 state_d = S_T0;
      end
      S_T6:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MARin    = 1'b0;
    bus.Zin      = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.alu_op   = 5'b00000;
    bus.illegal  = 1'b0;
    bus.run      = (state_q != S_IDLE) &&
                   (state_q != S_HALT);

    unique case (state_q)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        unique case (cls)
          C_TWO: begin
            bus.Grb  = 1'b1;
            bus.Rout = 1'b1;
            bus.Yin  = 1'b1;
          end
          C_UNARY: begin
            bus.Grb    = 1'b1;
            bus.Rout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = opc;
          end
          C_MULDIV: begin
            bus.Gra  = 1'b1;
            bus.Rout = 1'b1;
            bus.Yin  = 1'b1;
          end
          C_ILL:   bus.illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        unique case (cls)
          C_TWO: begin
            bus.Grc    = 1'b1;
            bus.Rout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = opc;
          end
          C_UNARY: begin
            bus.Zlowout = 1'b1;
            bus.Gra     = 1'b1;
            bus.Rin     = 1'b1;
          end
          C_MULDIV: begin
            bus.Grb    = 1'b1;
            bus.Rout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = opc;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (cls)
          C_TWO: begin
            bus.Zlowout = 1'b1;
            bus.Gra     = 1'b1;
            bus.Rin     = 1'b1;
          end
          C_MULDIV: begin
            bus.Zlowout = 1'b1;
            bus.LOin    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        if (cls == C_MULDIV) begin
          bus.Zhighout = 1'b1;
          bus.HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001: clock  input  1  single system clock; all state changes on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: start  input  1  begin fetch/execute from IDLE; ignored in all other states.
REQ-004: mem_ready  input  1  memory read-complete handshake, sampled in T1.
REQ-005: IR  input  32  instruction register contents; opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
REQ-006: PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, HIin, LOin  output  1 each  datapath bus and register strobes.
REQ-007: Gra, Grb, Grc, Rin, Rout  output  1 each  select-and-encode controls for the register file.
REQ-008: alu_op  output  5  ALU operation, equal to the opcode while Zin is asserted in execute; 5'b00000 otherwise.
REQ-009: run  output  1  high in T0-T6, low in IDLE and HALT.
REQ-010: illegal  output  1  one-cycle pulse in T3 for an unsupported opcode.

Function
REQ-011: States are IDLE, T0, T1, T2, T3, T4, T5, T6 and HALT; outputs are a Moore function of state and IR only, held for the whole cycle.
REQ-012: IDLE drives all outputs 0 and moves to T0 on start=1.
REQ-013: T0 asserts PCout, MARin, IncPC and Zin, then moves to T1.
REQ-014: T1 asserts Zlowout, PCin, Read and MDRin, then moves to T2.
REQ-015: T2 asserts MDRout and IRin, then moves to T3.
REQ-016: Two-operand ops (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011) run T3: Grb, Rout, Yin; T4: Grc, Rout, Zin, alu_op; T5: Zlowout, Gra, Rin; then T0 (6 cycles).
REQ-017: Unary ops (neg 10001, not 10010) run T3: Grb, Rout, Zin, alu_op; T4: Zlowout, Gra, Rin; then T0 (5 cycles).
REQ-018: mul 01111 and div 10000 run T3: Gra, Rout, Yin; T4: Grb, Rout, Zin, alu_op; T5: Zlowout, LOin; T6: Zhighout, HIin; then T0 (7 cycles).
REQ-019: nop 11010 goes from T3 to T0 with no strobes (4 cycles).
REQ-020: halt 11011 goes from T3 to HALT; HALT drives all outputs 0 and is left only by reset.
REQ-021: Any other opcode pulses illegal in T3, is otherwise executed as nop, and next goes to T0.
REQ-022: At most one of PCout, Zlowout, Zhighout, MDRout and Rout is high in any cycle (single-driver bus).
REQ-023: Only IR[31:15] affects decoding; IR[14:0] is ignored.

Reset
REQ-024: reset=1 at a rising edge forces IDLE and all outputs 0 in the next cycle, in any state, including mid-instruction and during a T1 wait.
REQ-025: reset has priority over start and mem_ready in the same cycle.

Configuration
REQ-026: MEM_WAIT_EN defined: T1 holds, with its strobes still asserted, until the edge where mem_ready=1, then moves to T2; a read that is already ready takes one T1 cycle.
REQ-027: MEM_WAIT_EN undefined: T1 is always exactly one cycle and mem_ready is ignored; the port remains present.

Verification
REQ-028: reset, start=1, IR=32'h28918000 (and R1,R2,R3) -> T3 Grb/Rout/Yin; T4 Grc/Rout/Zin with alu_op=5'b00101; T5 Zlowout/Gra/Rin; T0 on the 7th edge after start.
REQ-029: IR=32'h7A280000 (mul R4,R5) -> T5 Zlowout/LOin; T6 Zhighout/HIin; back to T0; run stays 1 throughout.
REQ-030: With MEM_WAIT_EN, mem_ready held low for 3 cycles in T1 -> Read/MDRin stay high for 4 cycles; IRin is asserted in the cycle after mem_ready=1.
REQ-031: IR=32'hD8000000 (halt) -> HALT after T3, run=0 and outputs 0 for 20 cycles with start pulsed; reset then restores IDLE.
REQ-032: IR=32'hF8000000 -> illegal=1 for exactly one cycle in T3, no Rin/LOin/HIin, next state T0.
REQ-033: reset asserted in T4 of an add -> next cycle IDLE, all outputs 0, run=0; a following start restarts at T0.
